// File: rtl/slv_i2c_line_cond.sv
// -----------------------------------------------------------------------------
// slv_i2c_line_cond
//
// Input conditioner for the I2C slave. Brings the raw, asynchronous SCL/SDA
// pins into the CLK domain, removes short glitches, and produces the edge and
// SCL mid-phase strobes that the slave FSM runs from.
//
// Parameters
//   SYNC_STG  synchroniser flops per line (>= 2)
//   FILT_LEN  CLKs a new synchronised level must persist before it is
//             accepted (0 bypasses the filter)
//   CNT_W     width of the SCL phase counter and latched phase lengths (>= 3)
//
// Ports
//   CLK           in   system clock
//   RST_n         in   asynchronous reset, active-low
//   IO_SCL        in   raw SCL pin (asynchronous)
//   IO_SDA        in   raw SDA pin (asynchronous)
//   O_SCL         out  synchronised, filtered SCL
//   O_SDA         out  synchronised, filtered SDA
//   O_RS_SCL      out  1-CLK strobe, SCL rising edge
//   O_FL_SCL      out  1-CLK strobe, SCL falling edge
//   O_RS_SDA      out  1-CLK strobe, SDA rising edge
//   O_FL_SDA      out  1-CLK strobe, SDA falling edge
//   O_MDL_LW_SCL  out  1-CLK strobe in the middle of the SCL low phase
//   O_MDL_HG_SCL  out  1-CLK strobe in the middle of the SCL high phase
//   O_START       out  1-CLK START strobe
//   O_STOP        out  1-CLK STOP strobe
//
// Build option
//   SLV_I2C_START_STOP_DET_EN  when defined, O_START/O_STOP are decoded from
//                              the SDA edge strobes while SCL is high; when
//                              undefined they are tied to 0.
//
// Timing notes
//   A raw level change reaches O_SCL/O_SDA SYNC_STG+FILT_LEN CLKs later. All
//   strobes are registered: every strobe flop is loaded from the *next*
//   value of the line/counter, so a strobe is high in exactly the CLK in
//   which the corresponding condition becomes visible on the outputs.
// -----------------------------------------------------------------------------
module slv_i2c_line_cond #(
  parameter int SYNC_STG = 2,
  parameter int FILT_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic IO_SCL,
  input  logic IO_SDA,
  output logic O_SCL,
  output logic O_SDA,
  output logic O_RS_SCL,
  output logic O_FL_SCL,
  output logic O_RS_SDA,
  output logic O_FL_SDA,
  output logic O_MDL_LW_SCL,
  output logic O_MDL_HG_SCL,
  output logic O_START,
  output logic O_STOP
);

  // Filter counter only ever holds 0 .. FILT_LEN-1.
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(4);

  // Line index 0 = SCL, 1 = SDA throughout.
  logic [1:0]               w_raw;
  logic [1:0][SYNC_STG-1:0] r_sync;
  logic [1:0]               w_syn;
  logic [1:0]               w_line;      // current conditioned level
  logic [1:0]               w_line_nxt;  // level after the coming CLK edge

  assign w_raw = {IO_SDA, IO_SCL};

  // ---------------------------------------------------------------------------
  // Synchroniser chains, idle-high out of reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync <= '1;
    end else begin
      for (int l = 0; l < 2; l++) begin
        r_sync[l] <= {r_sync[l][SYNC_STG-2:0], w_raw[l]};
      end
    end
  end

  always_comb begin
    w_syn = '0;
    for (int l = 0; l < 2; l++) begin
      w_syn[l] = r_sync[l][SYNC_STG-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter
  // ---------------------------------------------------------------------------
  if (FILT_LEN == 0) begin : g_bypass
    // The conditioned line is the last sync stage; its next value is
    // whatever currently sits in the stage before it.
    assign w_line = w_syn;
    always_comb begin
      w_line_nxt = '0;
      for (int l = 0; l < 2; l++) begin
        w_line_nxt[l] = r_sync[l][SYNC_STG-2];
      end
    end
  end else begin : g_filt
    logic [1:0]          r_filt;
    logic [1:0][FCW-1:0] r_fcnt;
    logic [1:0]          w_diff;
    logic [1:0]          w_take;

    // w_take marks the FILT_LEN-th consecutive mismatching CLK.
    always_comb begin
      w_diff     = '0;
      w_take     = '0;
      w_line_nxt = '0;
      for (int l = 0; l < 2; l++) begin
        w_diff[l]     = w_syn[l] ^ r_filt[l];
        w_take[l]     = w_diff[l] && (r_fcnt[l] == FCW'(FILT_LEN - 1));
        w_line_nxt[l] = w_take[l] ? w_syn[l] : r_filt[l];
      end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        r_filt <= '1;
        r_fcnt <= '0;
      end else begin
        r_filt <= w_line_nxt;
        for (int l = 0; l < 2; l++) begin
          if (!w_diff[l] || w_take[l]) begin
            r_fcnt[l] <= '0;
          end else begin
            r_fcnt[l] <= r_fcnt[l] + 1'b1;
          end
        end
      end
    end

    assign w_line = r_filt;
  end

  assign O_SCL = w_line[0];
  assign O_SDA = w_line[1];

  // ---------------------------------------------------------------------------
  // Edge strobes
  // ---------------------------------------------------------------------------
  logic [1:0] w_rs_nxt;
  logic [1:0] w_fl_nxt;
  logic [1:0] r_rs;
  logic [1:0] r_fl;

  assign w_rs_nxt =  w_line_nxt & ~w_line;
  assign w_fl_nxt = ~w_line_nxt &  w_line;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_rs <= '0;
      r_fl <= '0;
    end else begin
      r_rs <= w_rs_nxt;
      r_fl <= w_fl_nxt;
    end
  end

  assign O_RS_SCL = r_rs[0];
  assign O_FL_SCL = r_fl[0];
  assign O_RS_SDA = r_rs[1];
  assign O_FL_SDA = r_fl[1];

  // ---------------------------------------------------------------------------
  // SCL phase measurement
  //   r_cnt_ph is 0 in the CLK of an SCL edge strobe and counts up
  //   (saturating) afterwards. On each edge the phase that just ended is
  //   r_cnt_ph+1 CLKs long. That length is only trusted if the phase began
  //   at a real edge (r_ph_ok), did not saturate, and is long enough to have
  //   a middle distinct from its edge CLK.
  // ---------------------------------------------------------------------------
  logic             w_scl_edge_nxt;
  logic             w_sat;
  logic [CNT_W-1:0] w_len;
  logic             w_len_ok;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_lw_len_nxt;
  logic [CNT_W-1:0] w_hg_len_nxt;
  logic             w_lw_vld_nxt;
  logic             w_hg_vld_nxt;
  logic             w_mdl_lw_nxt;
  logic             w_mdl_hg_nxt;

  logic [CNT_W-1:0] r_cnt_ph;
  logic [CNT_W-1:0] r_lw_len;
  logic [CNT_W-1:0] r_hg_len;
  logic             r_lw_vld;
  logic             r_hg_vld;
  logic             r_ph_ok;
  logic             r_mdl_lw;
  logic             r_mdl_hg;

  always_comb begin
    w_scl_edge_nxt = w_rs_nxt[0] | w_fl_nxt[0];
    w_sat          = (r_cnt_ph == CNT_MAX);
    w_len          = r_cnt_ph + 1'b1;
    w_len_ok       = r_ph_ok && !w_sat && (w_len >= MIN_LEN);

    w_cnt_nxt = r_cnt_ph;
    if (w_scl_edge_nxt) begin
      w_cnt_nxt = '0;
    end else if (!w_sat) begin
      w_cnt_nxt = r_cnt_ph + 1'b1;
    end

    // Rising edge closes a low phase, falling edge closes a high phase.
    w_lw_len_nxt = w_rs_nxt[0] ? w_len    : r_lw_len;
    w_lw_vld_nxt = w_rs_nxt[0] ? w_len_ok : r_lw_vld;
    w_hg_len_nxt = w_fl_nxt[0] ? w_len    : r_hg_len;
    w_hg_vld_nxt = w_fl_nxt[0] ? w_len_ok : r_hg_vld;

    // The counter passes each value at most once per phase, so these fire
    // at most once; the half-length is always >= 2, so never on the edge CLK.
    w_mdl_lw_nxt = !w_line_nxt[0] && w_lw_vld_nxt && (w_cnt_nxt == (w_lw_len_nxt >> 1));
    w_mdl_hg_nxt =  w_line_nxt[0] && w_hg_vld_nxt && (w_cnt_nxt == (w_hg_len_nxt >> 1));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt_ph <= '0;
      r_lw_len <= '0;
      r_hg_len <= '0;
      r_lw_vld <= 1'b0;
      r_hg_vld <= 1'b0;
      r_ph_ok  <= 1'b0;
      r_mdl_lw <= 1'b0;
      r_mdl_hg <= 1'b0;
    end else begin
      r_cnt_ph <= w_cnt_nxt;
      r_lw_len <= w_lw_len_nxt;
      r_hg_len <= w_hg_len_nxt;
      r_lw_vld <= w_lw_vld_nxt;
      r_hg_vld <= w_hg_vld_nxt;
      r_ph_ok  <= r_ph_ok | w_scl_edge_nxt;
      r_mdl_lw <= w_mdl_lw_nxt;
      r_mdl_hg <= w_mdl_hg_nxt;
    end
  end

  assign O_MDL_LW_SCL = r_mdl_lw;
  assign O_MDL_HG_SCL = r_mdl_hg;

  // ---------------------------------------------------------------------------
  // START / STOP decode
  //   An SDA edge only counts while SCL is stably high: a coincident SCL edge
  //   makes the bus condition ambiguous, so neither strobe is raised.
  // ---------------------------------------------------------------------------
`ifdef SLV_I2C_START_STOP_DET_EN
  logic w_scl_edge;
  assign w_scl_edge = r_rs[0] | r_fl[0];
  assign O_START    = r_fl[1] & w_line[0] & ~w_scl_edge;
  assign O_STOP     = r_rs[1] & w_line[0] & ~w_scl_edge;
`else
  assign O_START = 1'b0;
  assign O_STOP  = 1'b0;
`endif

endmodule
